// File: rtl/sap1_pkg.sv
// sap1_pkg: shared types for the SAP-1 derived blocks.
package sap1_pkg;
   typedef enum logic [1:0] {
      PROG    = 2'd0,
      TO_RUN  = 2'd1,
      RUN     = 2'd2,
      TO_PROG = 2'd3
   } mar_state_t;
endpackage

// File: rtl/addr_counter.sv
// addr_counter: loadable wrapping up-counter with a one-cycle wrap pulse.
module addr_counter #(
   parameter int AW = 4
) (
   input  logic          clk_i,
   input  logic          clr_i,
   input  logic          ld_i,
   input  logic          inc_i,
   input  logic [AW-1:0] d_i,
   output logic [AW-1:0] q_o,
   output logic          wrap_o
);
   logic [AW-1:0] cnt_q;
   logic          wrap_q;
   always_ff @(posedge clk_i) begin
      if (clr_i) begin
         cnt_q  <= '0;
         wrap_q <= 1'b0;
      end else begin
         cnt_q  <= ld_i ? d_i : inc_i ? cnt_q + 1'b1 : cnt_q;
         wrap_q <= inc_i && !ld_i && (&cnt_q);
      end
   end
   assign q_o    = cnt_q;
   assign wrap_o = wrap_q;
endmodule

// File: rtl/mar_seq.sv
// mar_seq: memory address register with programming/run modes and a settle
// cycle on every mode change so the RAM address never glitches.
module mar_seq
   import sap1_pkg::*;
#(
   parameter int AW      = 4,
   parameter int AUTO_EN = 1
) (
   input  logic          CLK,
   input  logic          CLR,
   input  logic          SELECT,
   input  logic          Lm,
   input  logic [AW-1:0] D,
   input  logic [AW-1:0] A,
   input  logic          AUTO,
   input  logic          STEP,
   input  logic          PLOAD,
   output logic [AW-1:0] Out,
   output logic          VALID,
   output logic          WRAP
);
   mar_state_t    state_q, state_d;
   logic [AW-1:0] q_q, h_q, p;
   logic          valid_q, wrap, in_prog, in_run, use_p;
   assign in_prog = state_q == PROG;
   assign in_run  = state_q == RUN;
   assign use_p   = (AUTO_EN != 0) && AUTO;
   // Both settle states resolve on SELECT alone: either commit or abort.
   always_comb begin
      state_d = in_prog ? (SELECT ? TO_RUN : PROG) :
                in_run  ? (SELECT ? RUN : TO_PROG) :
                          (SELECT ? RUN : PROG);
   end
   assign Out = in_prog ? (use_p ? p : A) : in_run ? q_q : h_q;
   always_ff @(posedge CLK) begin
      if (CLR) begin
         state_q <= PROG;
         q_q     <= '0;
         h_q     <= '0;
         valid_q <= 1'b1;
      end else begin
         state_q <= state_d;
         valid_q <= (state_d == PROG) || (state_d == RUN);
         if (in_run && Lm) q_q <= D;
         if (in_prog || in_run) h_q <= Out;
      end
   end
   generate
      if (AUTO_EN != 0) begin : g_ptr
         addr_counter #(.AW(AW)) u_ptr (
            .clk_i  (CLK),
            .clr_i  (CLR),
            .ld_i   (in_prog && PLOAD),
            .inc_i  (in_prog && STEP),
            .d_i    (A),
            .q_o    (p),
            .wrap_o (wrap)
         );
      end else begin : g_noptr
         assign p    = '0;
         assign wrap = 1'b0;
      end
   endgenerate
   assign VALID = valid_q;
   assign WRAP  = wrap;
endmodule

// File: tb/tb_mar_seq.sv
// tb_mar_seq: scoreboard bench for AW=4 and AW=8 instances driven in parallel.
module tb_mar_seq;
   logic       CLK = 1'b0;
   logic       CLR = 1'b1, SELECT = 1'b0, Lm = 1'b0, AUTO = 1'b0, STEP = 1'b0, PLOAD = 1'b0;
   logic [7:0] A8 = 8'h09, D8 = 8'h00;
   logic [3:0] out4;
   logic [7:0] out8;
   logic       valid4, valid8, wrap4, wrap8;
   int         n_cmp = 0, n_err = 0;
   bit         done = 1'b0;

   always #5 CLK = ~CLK;

   mar_seq #(.AW(4), .AUTO_EN(1)) u4 (
      .CLK(CLK), .CLR(CLR), .SELECT(SELECT), .Lm(Lm), .D(D8[3:0]), .A(A8[3:0]),
      .AUTO(AUTO), .STEP(STEP), .PLOAD(PLOAD), .Out(out4), .VALID(valid4), .WRAP(wrap4)
   );
   mar_seq #(.AW(8), .AUTO_EN(1)) u8 (
      .CLK(CLK), .CLR(CLR), .SELECT(SELECT), .Lm(Lm), .D(D8), .A(A8),
      .AUTO(AUTO), .STEP(STEP), .PLOAD(PLOAD), .Out(out8), .VALID(valid8), .WRAP(wrap8)
   );

   // Reference: a stable mode (0 prog, 1 run) plus a "switching" flag.
   typedef struct packed {
      logic       mode;
      logic       pend;
      logic [7:0] q, p, h;
      logic       wrap;
   } ms_t;
   typedef struct packed {
      logic [7:0] o4, o8;
      logic       v4, v8, w4, w8;
   } exp_t;

   ms_t  m4, m8;
   exp_t sb[$];

   function automatic logic [7:0] addr_of(ms_t m, logic [7:0] mask);
      return m.pend ? m.h : m.mode ? m.q : (AUTO ? m.p : (A8 & mask));
   endfunction

   function automatic ms_t next_of(ms_t m, logic [7:0] mask);
      ms_t n = m;
      if (CLR) return '0;
      n.wrap = 1'b0;
      if (!m.pend) begin
         n.h = addr_of(m, mask);
         if (m.mode && Lm) n.q = D8 & mask;
         if (!m.mode && PLOAD) n.p = A8 & mask;
         else if (!m.mode && STEP) begin
            n.wrap = (m.p == mask);
            n.p    = (m.p + 8'd1) & mask;
         end
         n.pend = (SELECT != m.mode);
      end else begin
         n.pend = 1'b0;
         n.mode = SELECT;
      end
      return n;
   endfunction

   task automatic tick();
      exp_t e;
      #1;
      e.o4 = addr_of(m4, 8'h0F);
      e.o8 = addr_of(m8, 8'hFF);
      e.v4 = !m4.pend;
      e.v8 = !m8.pend;
      e.w4 = m4.wrap;
      e.w8 = m8.wrap;
      sb.push_back(e);
      m4 = next_of(m4, 8'h0F);
      m8 = next_of(m8, 8'hFF);
      @(negedge CLK);
   endtask

   task automatic chk(string name, int act, int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge CLK);
         #2;
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("out4", int'(out4), int'(e.o4));
            chk("valid4", int'(valid4), int'(e.v4));
            chk("wrap4", int'(wrap4), int'(e.w4));
            chk("out8", int'(out8), int'(e.o8));
            chk("valid8", int'(valid8), int'(e.v8));
            chk("wrap8", int'(wrap8), int'(e.w8));
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "timeout");
   end

   initial begin : driver
      m4 = '0;
      m8 = '0;
      @(negedge CLK);
      tick(); tick();
      CLR = 1'b0; tick();
      AUTO = 1'b1; tick();
      PLOAD = 1'b1; A8 = 8'hFE; tick();
      PLOAD = 1'b0; STEP = 1'b1; tick(); tick(); tick();
      STEP = 1'b0; tick();
      PLOAD = 1'b1; STEP = 1'b1; A8 = 8'h03; tick();
      PLOAD = 1'b0; STEP = 1'b0; tick();
      AUTO = 1'b0; A8 = 8'h05; tick();
      SELECT = 1'b1; tick(); tick(); tick();
      Lm = 1'b1; D8 = 8'h0B; tick();
      Lm = 1'b0; tick();
      SELECT = 1'b0; tick();
      SELECT = 1'b1; tick(); tick(); tick();
      STEP = 1'b1; tick();
      STEP = 1'b0; SELECT = 1'b0; tick(); tick();
      Lm = 1'b1; D8 = 8'h03; tick();
      Lm = 1'b0; SELECT = 1'b1; tick(); tick(); tick();
      Lm = 1'b1; D8 = 8'h7C; SELECT = 1'b0; tick();
      Lm = 1'b0; tick(); tick();
      STEP = 1'b1; AUTO = 1'b1; SELECT = 1'b1; tick();
      STEP = 1'b0; tick();
      CLR = 1'b1; tick();
      CLR = 1'b0; tick();
      SELECT = 1'b0; PLOAD = 1'b1; A8 = 8'hFE; tick();
      PLOAD = 1'b0; STEP = 1'b1; tick(); tick(); tick();
      STEP = 1'b0; tick();
      for (int i = 0; i < 3000; i++) begin
         CLR    = ($urandom_range(0, 79) == 0);
         if ($urandom_range(0, 5) == 0) SELECT = ~SELECT;
         Lm     = $urandom_range(0, 1);
         STEP   = ($urandom_range(0, 3) != 0);
         PLOAD  = ($urandom_range(0, 29) == 0);
         AUTO   = ($urandom_range(0, 3) != 0);
         A8     = 8'($urandom);
         D8     = 8'($urandom);
         tick();
      end
      CLR = 1'b0; STEP = 1'b0; PLOAD = 1'b0; Lm = 1'b0;
      tick(); tick();
      @(negedge CLK);
      chk("scoreboard_drained", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/mar_seq.md
# mar_seq

Parametrised successor to the SAP-1 memory address register. It drives the RAM address in two modes: programming mode, with manual switches or an auto-advancing program pointer, and run mode, with the address latched from the central bus. Mode changes pass through a one-cycle settle state so the RAM never sees a glitched address. It sits between the bus/control unit and the RAM address input.

## Interface
Parameters:
- AW, 4, address width in bits; RAM depth is 2^AW.
- AUTO_EN, 1, when 0 the program pointer is not built, AUTO is ignored and treated as 0.

Ports:
- CLK  in  1  clock, all state changes on its rising edge.
- CLR  in  1  reset; synchronous, active-high.
- SELECT  in  1  0 = programming mode, 1 = normal execution.
- Lm  in  1  load MAR from D, from the control unit; honoured only in RUN.
- D  in  AW  address from the central bus.
- A  in  AW  manual address switches (programming mode).
- AUTO  in  1  programming-mode source: 0 = A, 1 = program pointer P.
- STEP  in  1  advance P by one; honoured only in PROG.
- PLOAD  in  1  preset P from A; honoured only in PROG.
- Out  out  AW  effective RAM address.
- VALID  out  1  1 when Out is stable for the current mode; 0 in settle states.
- WRAP  out  1  one-cycle pulse when P wraps from 2^AW-1 to 0.

## Operation
- Registers:
  - Q (AW), the run address.
  - P (AW), the program pointer.
  - H (AW), the held address.
  - state (2 bits).
  - WRAP (1).
- States:
  - PROG to TO_RUN when SELECT=1.
  - TO_RUN to RUN when SELECT=1, else back to PROG (abort).
  - RUN to TO_PROG when SELECT=0.
  - TO_PROG to PROG when SELECT=0, else back to RUN (abort).
  - Otherwise the state holds.
- Out, combinational from registers/inputs:
  - PROG: AUTO ? P : A.
  - RUN: Q.
  - TO_RUN/TO_PROG: H.
- H captures the current Out every cycle in PROG and RUN, and holds in the settle states.
- VALID = 1 in PROG and RUN; 0 in the settle states.
- Lm: in RUN, Q <= D. In all other states Lm is ignored and Q holds.
- P in PROG:
  - PLOAD has priority: P <= A.
  - Else if STEP: P <= P+1, modulo 2^AW.
  - If P == 2^AW-1 and STEP (without PLOAD): P <= 0 and WRAP = 1 the next cycle.
  - Outside PROG, P holds.
- WRAP is registered and high for exactly one cycle per wrap; it never stays high over consecutive cycles unless STEP keeps wrapping, which needs 2^AW steps.
- All arithmetic is unsigned, AW bits; overflow is discarded, and WRAP is the only indication.

## Timing
- Reset values, while CLR=1 at an edge:
  - state = PROG; Q = 0; P = 0; H = 0; WRAP = 0; VALID = 1.
  - After reset, Out = A if AUTO=0, else 0.
- CLR dominates all other inputs in the same cycle.
- CLR mid-transition returns to PROG immediately; a pending Lm/STEP is discarded.
- Lm latency: Q, and therefore Out in RUN, shows D one edge after the Lm-high cycle.
- STEP/PLOAD latency: one edge.
- Mode-switch latency: SELECT change to new-mode Out takes two edges. Out equals H, the last stable address, in between.
- A SELECT pulse shorter than one cycle at an edge never reaches the new mode; it aborts back with Out unchanged.
- A and AUTO affect Out combinationally in PROG only; they are not registered.
- Simultaneous events:
  - Lm with SELECT 1 to 0 in RUN: Lm is honoured, and Q updates on the same edge the state enters TO_PROG.
  - STEP with SELECT 0 to 1 in PROG: STEP is honoured on the same edge.

## Structure
- A shared package sap1_pkg holds the mar_state_t enum (PROG, TO_RUN, RUN, TO_PROG) with 2-bit encoding. Add it if the package is absent.
- One sub-module, addr_counter: AW-bit register with synchronous clear, load, increment and a registered wrap pulse. It implements P and is generated only when AUTO_EN=1.
- Q is a plain AW-bit loadable register, the parametrised equivalent of the 74173 register; it is inline in mar_seq.

## Test plan
- Reset: AW=4, hold CLR=1 for 2 cycles with A=4'h9, AUTO=0. Required: Out=9, VALID=1, WRAP=0. Set AUTO=1: Out=0.
- Program pointer: PLOAD with A=4'hE, then 3× STEP in PROG. Required: P sequence E, F, 0, 1; WRAP=1 only in the cycle after the F-to-0 edge; PLOAD+STEP same cycle loads A.
- Mode switch: in PROG, Out=5 (A=5). Set SELECT=1. Required: next cycle VALID=0 and Out=5; following cycle VALID=1 and Out=Q=0. Lm with D=4'hB: Out=B one edge later.
- Abort: in RUN with Out=B, pulse SELECT=0 for exactly one cycle. Required: TO_PROG then RUN; Out stays B throughout; VALID dips for one cycle.
- Ignored controls: Lm=1, D=3 in PROG leaves Q unchanged, so RUN later shows the old Q. STEP=1 in RUN leaves P unchanged.
- Reset mid-transition: assert CLR in TO_RUN. Required: next cycle state PROG, VALID=1, Q=P=0. Repeat with AW=8: the wrap occurs at 8'hFF to 0.
